pixel_collision_latch: RTL and testbench

- Per-frame collision and scoring stage fed by the colour mapper's per-pixel layer flags (ship opaque, rock i opaque, shot j lit).
- Accumulates overlaps during the visible scan. At vertical sync it commits one-cycle kill pulses to the rock/shot/ship respawn-delay logic and updates the BCD score and lives.
- Kill pulses feed the existing spawn-delay inputs; the score drives the hex display.

---
 rtl/collision_pkg.sv | 10 +
 rtl/bcd_add4_sat.sv | 32 +++
 rtl/pixel_collision_latch.sv | 159 +++++++++++++++
 tb/tb_pixel_collision_latch.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/collision_pkg.sv
// Shared types for the per-frame collision/scoring stage.
package collision_pkg;

  typedef enum logic [1:0] {SCAN, COMMIT, CLEAR, WAIT_HI} state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [15:0] MAX_SCORE_BCD = 16'h9999;

endpackage

// File: rtl/bcd_add4_sat.sv
// 4-digit BCD score plus a small binary increment (0..63), clamped at 9999.
module bcd_add4_sat
  import collision_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [5:0]  inc_i,
  output logic [15:0] sum_o
);

  bcd_digit_t b [4];
  logic [4:0] d;
  logic       c;

  always_comb begin
    // Increment split into tens/ones digits; upper digits only take carries.
    b[0]  = 4'(inc_i % 6'd10);
    b[1]  = 4'(inc_i / 6'd10);
    b[2]  = 4'd0;
    b[3]  = 4'd0;
    sum_o = '0;
    c     = 1'b0;
    d     = '0;
    for (int k = 0; k < 4; k++) begin
      d = {1'b0, a_i[4*k +: 4]} + {1'b0, b[k]} + {4'd0, c};
      c = (d > 5'd9);
      if (c) d = d - 5'd10;
      sum_o[4*k +: 4] = d[3:0];
    end
    if (c) sum_o = MAX_SCORE_BCD;
  end

endmodule

// File: rtl/pixel_collision_latch.sv
// Accumulates layer overlaps over the visible scan and commits kill pulses,
// BCD score and lives at vsync. COLLISION_INVULN_EN adds post-death immunity.
module pixel_collision_latch
  import collision_pkg::*;
#(
  parameter int NUM_ROCKS     = 4,
  parameter int NUM_SHOTS     = 4,
  parameter int INIT_LIVES    = 3,
  parameter int ROCK_POINTS   = 1,
  parameter int INVULN_FRAMES = 120
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 vs,
  input  logic                 restart,
  input  logic                 ship_pix,
  input  logic [NUM_ROCKS-1:0] rock_pix,
  input  logic [NUM_SHOTS-1:0] shot_pix,
  input  logic [NUM_ROCKS-1:0] rock_active,
  input  logic [NUM_SHOTS-1:0] shot_active,
  input  logic                 ship_active,
  output logic [NUM_ROCKS-1:0] reset_rocks,
  output logic [NUM_SHOTS-1:0] reset_shots,
  output logic                 reset_ship,
  output logic [15:0]          score,
  output logic [2:0]           lives,
  output logic                 game_over
);

  state_e                              state_q, state_d;
  logic                                vs_q;
  logic [NUM_ROCKS-1:0][NUM_SHOTS-1:0] rs_acc_q, rs_acc_d;
  logic [NUM_ROCKS-1:0]                sr_acc_q, sr_acc_d, rocks_q, rocks_d, rock_shot;
  logic [NUM_SHOTS-1:0]                shots_q, shots_d, shot_kill;
  logic                                ship_q, ship_d, ship_kill;
  logic                                restart_q, restart_d, vuln, over;
  logic [15:0]                         score_q, score_d, score_sum;
  logic [2:0]                          lives_q, lives_d;
  logic [5:0]                          inc;

  assign over      = (lives_q == 3'd0);
  assign ship_kill = (|sr_acc_q) & ~over & ~restart_q;
  assign inc       = 6'(ROCK_POINTS * $countones(rock_shot));

  always_comb begin
    shot_kill = '0;
    for (int i = 0; i < NUM_ROCKS; i++) begin
      rock_shot[i] = |rs_acc_q[i];
      shot_kill    = shot_kill | rs_acc_q[i];
    end
  end

  bcd_add4_sat u_add (.a_i(score_q), .inc_i(inc), .sum_o(score_sum));

`ifdef COLLISION_INVULN_EN
  localparam int IW = $clog2(INVULN_FRAMES + 2);
  logic [IW-1:0] inv_q, inv_d;

  assign vuln = (inv_q == '0);

  always_comb begin
    inv_d = inv_q;
    if (state_q == COMMIT) begin
      if (ship_kill | restart_q) inv_d = IW'(INVULN_FRAMES);
      else if (inv_q != '0)      inv_d = inv_q - IW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) inv_q <= '0;
    else          inv_q <= inv_d;
`else
  logic unused_invuln;
  assign unused_invuln = ^INVULN_FRAMES;
  assign vuln          = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    rs_acc_d  = rs_acc_q;
    sr_acc_d  = sr_acc_q;
    rocks_d   = '0;
    shots_d   = '0;
    ship_d    = 1'b0;
    score_d   = score_q;
    lives_d   = lives_q;
    restart_d = restart_q | restart;
    unique case (state_q)
      SCAN: begin
        if (vs) begin
          for (int i = 0; i < NUM_ROCKS; i++) begin
            for (int j = 0; j < NUM_SHOTS; j++)
              rs_acc_d[i][j] = rs_acc_q[i][j] |
                (rock_pix[i] & shot_pix[j] & rock_active[i] & shot_active[j]);
            sr_acc_d[i] = sr_acc_q[i] |
              (ship_pix & rock_pix[i] & rock_active[i] & ship_active & vuln);
          end
        end
        if (vs_q & ~vs) state_d = COMMIT;
      end
      COMMIT: begin
        rocks_d = rock_shot | sr_acc_q;
        shots_d = shot_kill;
        ship_d  = ship_kill;
        // A restart raised in this very cycle survives for the next frame.
        restart_d = restart;
        if (restart_q) begin
          score_d = '0;
          lives_d = 3'(INIT_LIVES);
        end else begin
          if (!over)    score_d = score_sum;
          if (ship_kill) lives_d = lives_q - 3'd1;
        end
        state_d = CLEAR;
      end
      CLEAR: begin
        rs_acc_d = '0;
        sr_acc_d = '0;
        state_d  = WAIT_HI;
      end
      WAIT_HI: if (vs) state_d = SCAN;
      default: state_d = WAIT_HI;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= WAIT_HI;
      vs_q      <= 1'b1;
      rs_acc_q  <= '0;
      sr_acc_q  <= '0;
      rocks_q   <= '0;
      shots_q   <= '0;
      ship_q    <= 1'b0;
      score_q   <= '0;
      lives_q   <= 3'(INIT_LIVES);
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vs_q      <= vs;
      rs_acc_q  <= rs_acc_d;
      sr_acc_q  <= sr_acc_d;
      rocks_q   <= rocks_d;
      shots_q   <= shots_d;
      ship_q    <= ship_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      restart_q <= restart_d;
    end
  end

  assign reset_rocks = rocks_q;
  assign reset_shots = shots_q;
  assign reset_ship  = ship_q;
  assign score       = score_q;
  assign lives       = lives_q;
  assign game_over   = over;

endmodule

// File: tb/tb_pixel_collision_latch.sv
// Randomized frames against a per-frame set model of kills, score and lives.
module tb_pixel_collision_latch;
  localparam int NR = 4, NS = 4, IL = 3, RP = 1;
`ifdef COLLISION_INVULN_EN
  localparam int INV = 2;
`else
  localparam int INV = 0;
`endif

  logic Clk = 0, Reset_n = 0, vs = 1, restart = 0, ship_pix = 0, ship_active = 1;
  logic [NR-1:0] rock_pix = '0, rock_active = '1;
  logic [NS-1:0] shot_pix = '0, shot_active = '1;
  logic [NR-1:0] reset_rocks;
  logic [NS-1:0] reset_shots;
  logic          reset_ship, game_over;
  logic [15:0]   score;
  logic [2:0]    lives;

  pixel_collision_latch #(.NUM_ROCKS(NR), .NUM_SHOTS(NS), .INIT_LIVES(IL),
    .ROCK_POINTS(RP), .INVULN_FRAMES(INV > 0 ? INV : 120)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .vs(vs), .restart(restart), .ship_pix(ship_pix),
    .rock_pix(rock_pix), .shot_pix(shot_pix), .rock_active(rock_active),
    .shot_active(shot_active), .ship_active(ship_active), .reset_rocks(reset_rocks),
    .reset_shots(reset_shots), .reset_ship(reset_ship), .score(score), .lives(lives),
    .game_over(game_over));

  always #10 Clk = ~Clk;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, fall_cyc = -100;
  always @(posedge Clk) cyc <= cyc + 1;

  // Model: which rocks/shots were hit this frame, which rocks the ship rammed.
  bit m_rs_rock [NR], m_rs_shot [NS], m_ram [NR];
  int m_score = 0, m_lives = IL, m_inv = 0;
  bit m_rst = 0;
  logic [NR-1:0] cap_rocks;
  logic [NS-1:0] cap_shots;
  logic          cap_ship;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) begin m_rs_rock[i] = 0; m_ram[i] = 0; end
    for (int j = 0; j < NS; j++) m_rs_shot[j] = 0;
  endtask

  always @(negedge Clk) begin
    logic [NR-1:0] er;
    logic [NS-1:0] es;
    logic          eship;
    er = '0; es = '0; eship = 0;
    if (Reset_n) begin
      if (cyc == fall_cyc + 2) begin
        int cnt;
        bit go, any_ram;
        cnt = 0; any_ram = 0; go = (m_lives == 0);
        for (int i = 0; i < NR; i++) begin
          er[i] = m_rs_rock[i] | m_ram[i];
          if (m_rs_rock[i]) cnt++;
          if (m_ram[i]) any_ram = 1;
        end
        for (int j = 0; j < NS; j++) es[j] = m_rs_shot[j];
        eship = any_ram && !go && !m_rst;
        if (m_rst) begin
          m_score = 0; m_lives = IL;
        end else begin
          if (!go) m_score = (m_score + RP * cnt > 9999) ? 9999 : m_score + RP * cnt;
          if (eship) m_lives--;
        end
        if (eship || m_rst) m_inv = INV;
        else if (m_inv > 0) m_inv--;
        m_rst = 0;
        model_clear();
        cap_rocks = reset_rocks; cap_shots = reset_shots; cap_ship = reset_ship;
      end
      chk("reset_rocks", 16'(reset_rocks), 16'(er));
      chk("reset_shots", 16'(reset_shots), 16'(es));
      chk("reset_ship", 16'(reset_ship), 16'(eship));
      chk("score", score, to_bcd(m_score));
      chk("lives", 16'(lives), 16'(m_lives));
      chk("game_over", 16'(game_over), 16'(m_lives == 0));
    end
  end

  task automatic tick(); @(posedge Clk); #1; endtask

  task automatic drive_pix(input logic s, input logic [NR-1:0] r, input logic [NS-1:0] sh);
    ship_pix = s; rock_pix = r; shot_pix = sh;
    for (int i = 0; i < NR; i++) begin
      for (int j = 0; j < NS; j++)
        if (r[i] && sh[j] && rock_active[i] && shot_active[j]) begin
          m_rs_rock[i] = 1; m_rs_shot[j] = 1;
        end
      if (s && r[i] && rock_active[i] && ship_active && m_inv == 0) m_ram[i] = 1;
    end
    tick();
  endtask

  task automatic frame_begin(); vs = 1; tick(); tick(); endtask

  task automatic frame_end();
    ship_pix = 0; rock_pix = '0; shot_pix = '0;
    tick();
    vs = 0; fall_cyc = cyc;
    repeat (4) tick();
  endtask

  task automatic do_restart(); restart = 1; m_rst = 1; tick(); restart = 0; endtask
  task automatic idle_frames(input int n);
    repeat (n) begin frame_begin(); frame_end(); end
  endtask
  task automatic ship_frame();
    frame_begin(); drive_pix(1, 4'b0001, 4'b0000); frame_end();
  endtask

  initial begin
    model_clear();
    repeat (3) tick();
    chk("rst score", score, 16'h0000);
    chk("rst lives", 16'(lives), 16'd3);
    chk("rst game_over", 16'(game_over), 16'd0);
    chk("rst rocks", 16'(reset_rocks), 16'd0);
    Reset_n = 1;
    tick();

    // Rock 1 shot by shot 2 for 3 cycles.
    frame_begin();
    repeat (3) drive_pix(0, 4'b0010, 4'b0100);
    frame_end();
    chk("t1 rocks", 16'(cap_rocks), 16'h0002);
    chk("t1 shots", 16'(cap_shots), 16'h0004);
    chk("t1 score", score, 16'h0001);
    chk("t1 lives", 16'(lives), 16'd3);

    // Ship rams rock 0.
    ship_frame();
    chk("t2 ship", 16'(cap_ship), 16'd1);
    chk("t2 rocks", 16'(cap_rocks), 16'h0001);
    chk("t2 shots", 16'(cap_shots), 16'h0000);
    chk("t2 lives", 16'(lives), 16'd2);
    chk("t2 score", score, 16'h0001);

    // Overlap on an inactive rock.
    rock_active = 4'b1101;
    frame_begin(); drive_pix(0, 4'b0010, 4'b0100); frame_end();
    chk("t3 rocks", 16'(cap_rocks), 16'h0000);
    chk("t3 score", score, 16'h0001);
    rock_active = '1;

    // Two more deaths reach game over, then a fourth overlap is ignored.
    repeat (2) begin idle_frames(INV); ship_frame(); end
    chk("go lives", 16'(lives), 16'd0);
    chk("go flag", 16'(game_over), 16'd1);
    idle_frames(INV);
    ship_frame();
    chk("go ship4", 16'(cap_ship), 16'd0);
    chk("go lives4", 16'(lives), 16'd0);
    frame_begin(); drive_pix(0, 4'b0100, 4'b0001); frame_end();
    chk("go frozen", score, 16'h0001);
    frame_begin(); do_restart(); frame_end();
    chk("rs lives", 16'(lives), 16'd3);
    chk("rs score", score, 16'h0000);
    chk("rs go", 16'(game_over), 16'd0);

`ifdef COLLISION_INVULN_EN
    idle_frames(INV);
    ship_frame();
    chk("inv kill", 16'(cap_ship), 16'd1);
    ship_frame(); chk("inv f1", 16'(cap_ship), 16'd0);
    ship_frame(); chk("inv f2", 16'(cap_ship), 16'd0);
    ship_frame(); chk("inv f3", 16'(cap_ship), 16'd1);
`endif

    // Random frames.
    for (int f = 0; f < 300; f++) begin
      rock_active = 4'($urandom) | 4'($urandom);
      shot_active = 4'($urandom) | 4'($urandom);
      ship_active = ($urandom_range(3) != 0);
      frame_begin();
      if ($urandom_range(7) == 0) do_restart();
      repeat ($urandom_range(6, 1))
        drive_pix(($urandom_range(3) == 0), 4'($urandom) & 4'($urandom),
                  4'($urandom) & 4'($urandom));
      frame_end();
    end
    rock_active = '1; shot_active = '1; ship_active = 1;

    // Ensure a nonzero score, then reset mid-scan with accumulators loaded.
    frame_begin(); drive_pix(0, 4'b1000, 4'b1000); frame_end();
    frame_begin();
    drive_pix(1, 4'hF, 4'hF);
    Reset_n = 0; #1;
    model_clear(); m_score = 0; m_lives = IL; m_inv = 0; m_rst = 0; fall_cyc = -100;
    chk("mr rocks", 16'(reset_rocks), 16'h0000);
    chk("mr ship", 16'(reset_ship), 16'd0);
    chk("mr score", score, 16'h0000);
    chk("mr lives", 16'(lives), 16'd3);
    tick(); tick();
    Reset_n = 1;
    tick();
    frame_end();
    idle_frames(1);
    chk("mr after rocks", 16'(cap_rocks), 16'h0000);
    chk("mr after ship", 16'(cap_ship), 16'd0);

    // Climb to 9996, then 9998, then saturate.
    while (m_score < 9996) begin
      frame_begin(); drive_pix(0, 4'hF, 4'hF); frame_end();
    end
    repeat (2) begin frame_begin(); drive_pix(0, 4'b0001, 4'b0001); frame_end(); end
    chk("sat 9998", score, 16'h9998);
    frame_begin(); drive_pix(0, 4'b0011, 4'b0011); frame_end();
    chk("sat 9999", score, 16'h9999);
    frame_begin(); drive_pix(0, 4'hF, 4'hF); frame_end();
    chk("sat hold", score, 16'h9999);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
